uart_rx_frame_check: RTL

Parametrised frame checker for the UART receiver. It consumes one oversampled decision per bit period (sampled_bit qualified by bit_valid) and walks the frame: start, DATA_WIDTH data bits LSB-first, optional parity, and STOP_BITS stop bits. It raises per-frame error pulses, saturating error counters and a validated data word. It sits between the data sampler and the RX register/FIFO stage, and combines start, parity and stop checking in one sequenced block.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_frame_check_if.sv | 32 +++
 rtl/sat_counter.sv | 38 +++
 rtl/uart_rx_frame_check.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame checker.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Expected parity bit; zero-extension of narrower words does not change the XOR.
  function automatic logic exp_parity(input logic [8:0] data, input logic par_typ);
    return (^data) ^ par_typ;
  endfunction

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// Sampler-side handshake and checker result bundle for uart_rx_frame_check.
interface uart_rx_frame_check_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
);
  logic                  sampled_bit;
  logic                  bit_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  clr_cnt;
  logic                  frame_busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [ERR_CNT_W-1:0]  glitch_cnt;
  logic [ERR_CNT_W-1:0]  par_err_cnt;
  logic [ERR_CNT_W-1:0]  stp_err_cnt;

  modport master (
    output sampled_bit, bit_valid, par_en, par_typ, clr_cnt,
    input  frame_busy, data_out, data_valid, strt_glitch, par_err, stp_err,
    input  glitch_cnt, par_err_cnt, stp_err_cnt
  );

  modport slave (
    input  sampled_bit, bit_valid, par_en, par_typ, clr_cnt,
    output frame_busy, data_out, data_valid, strt_glitch, par_err, stp_err,
    output glitch_cnt, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// Walks one UART frame per start bit and reports start, parity and stop errors.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_frame_check_if.slave  bus
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_e             state_d, state_q;
  logic [IDX_W-1:0]      bit_idx_d, bit_idx_q;
  logic                  stop_idx_d, stop_idx_q;
  logic [DATA_WIDTH-1:0] shift_d, shift_q;
  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic                  par_en_d, par_en_q;
  logic                  par_typ_d, par_typ_q;
  logic                  par_fail_d, par_fail_q;
  logic                  stp_fail_d, stp_fail_q;
  logic                  data_valid_d, data_valid_q;
  logic                  strt_glitch_d, strt_glitch_q;
  logic                  par_err_d, par_err_q;
  logic                  stp_err_d, stp_err_q;
  logic                  frame_busy_d, frame_busy_q;
  logic                  stp_bad_s;

  // Frame sequencing: everything holds except on bit_valid; pulses default low.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    stop_idx_d    = stop_idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    par_fail_d    = par_fail_q;
    stp_fail_d    = stp_fail_q;
    data_valid_d  = 1'b0;
    strt_glitch_d = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    stp_bad_s     = stp_fail_q | ~bus.sampled_bit;

    if (bus.bit_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.sampled_bit) begin
            strt_glitch_d = 1'b1;
          end else begin
            par_en_d   = bus.par_en;
            par_typ_d  = bus.par_typ;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            par_fail_d = 1'b0;
            stp_fail_d = 1'b0;
            state_d    = DATA;
          end
        end
        DATA: begin
          shift_d[bit_idx_q] = bus.sampled_bit;
          if (bit_idx_q == LAST_IDX) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
        PARITY: begin
          if (exp_parity(9'(shift_q), par_typ_q) != bus.sampled_bit) begin
            par_fail_d = 1'b1;
          end else begin
            par_fail_d = par_fail_q;
          end
          state_d = STOP;
        end
        STOP: begin
          stp_fail_d = stp_bad_s;
          // Every stop bit is consumed; the verdict lands on the last one.
          if (stop_idx_q == LAST_STOP) begin
            state_d      = IDLE;
            par_err_d    = par_fail_q;
            stp_err_d    = stp_bad_s;
            data_valid_d = ~par_fail_q & ~stp_bad_s;
            if (~par_fail_q & ~stp_bad_s) begin
              data_out_d = shift_q;
            end else begin
              data_out_d = data_out_q;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    frame_busy_d = (state_d != IDLE);
  end

  // Frame state and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      bit_idx_q     <= '0;
      stop_idx_q    <= 1'b0;
      shift_q       <= '0;
      data_out_q    <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      par_fail_q    <= 1'b0;
      stp_fail_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      frame_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      stop_idx_q    <= stop_idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      par_fail_q    <= par_fail_d;
      stp_fail_q    <= stp_fail_d;
      data_valid_q  <= data_valid_d;
      strt_glitch_q <= strt_glitch_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      frame_busy_q  <= frame_busy_d;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_glitch_cnt (
    .CLK (CLK), .RST (RST), .clr (bus.clr_cnt), .inc (strt_glitch_q), .cnt (bus.glitch_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_par_err_cnt (
    .CLK (CLK), .RST (RST), .clr (bus.clr_cnt), .inc (par_err_q), .cnt (bus.par_err_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_stp_err_cnt (
    .CLK (CLK), .RST (RST), .clr (bus.clr_cnt), .inc (stp_err_q), .cnt (bus.stp_err_cnt)
  );

  assign bus.frame_busy  = frame_busy_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.strt_glitch = strt_glitch_q;
  assign bus.par_err     = par_err_q;
  assign bus.stp_err     = stp_err_q;

endmodule
